// File: rtl/biu_arb_pkg.sv
// Shared types and constants for the BIU refill arbiter.
// Optional feature macro: BIU_ARB_RR_EN (round-robin priority pointer).
package biu_arb_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 32;

  // Owner encoding used by arb_owner and the priority pointer.
  localparam logic OWNER_ICU = 1'b0;
  localparam logic OWNER_DCU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/biu_arb_pri.sv
// Two-way winner selection: one-hot grant (bit 0 = icu, bit 1 = dcu).
// On a tie the pointer names the favoured requester.
import biu_arb_pkg::*;

module biu_arb_pri (
  input  logic       icu_req,
  input  logic       dcu_req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Pick a single winner; the pointer only matters when both request.
  always_comb begin
    grant = 2'b00;
    if (icu_req && dcu_req) begin
      grant = (ptr == OWNER_DCU) ? 2'b10 : 2'b01;
    end else if (icu_req) begin
      grant = 2'b01;
    end else if (dcu_req) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/biu_arb.sv
// BIU refill arbiter: shares one downstream request/response channel
// between the icache and dcache refill engines.
// Build option: define BIU_ARB_RR_EN for round-robin priority; otherwise
// the icache always wins a tie.
//
// Handshake: a requester holds req (and addr) high until it sees its
// one-cycle ack. The downstream side sees arb_axi_req high in REQ until
// axi_arb_ack; response beats are then forwarded only in DATA, only to
// the latched owner, until a beat with both data_valid and data_last.
import biu_arb_pkg::*;

module biu_arb #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icu_biu_req,
  input  logic [ADDR_W-1:0] icu_biu_addr,
  input  logic              dcu_biu_req,
  input  logic [ADDR_W-1:0] dcu_biu_addr,
  output logic              biu_icu_ack,
  output logic              biu_dcu_ack,
  output logic              biu_icu_data_valid,
  output logic              biu_dcu_data_valid,
  output logic              biu_icu_data_last,
  output logic              biu_dcu_data_last,
  output logic [DATA_W-1:0] biu_icu_data,
  output logic [DATA_W-1:0] biu_dcu_data,
  output logic              arb_axi_req,
  output logic [ADDR_W-1:0] arb_axi_addr,
  input  logic              axi_arb_ack,
  input  logic              axi_arb_data_valid,
  input  logic              axi_arb_data_last,
  input  logic [DATA_W-1:0] axi_arb_data,
  output logic              arb_owner,
  output logic              arb_busy,
  output state_e            arb_state
);

  state_e     state;
  state_e     state_nxt;
  logic       owner;
  logic       ptr;
  logic [1:0] grant;
  logic       in_req;
  logic       in_data;
  logic       burst_done;

`ifdef BIU_ARB_RR_EN
  // Round-robin pointer: after each finished burst favour the other side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= OWNER_ICU;
    end else if (burst_done) begin
      ptr <= ~owner;
    end
  end
`else
  assign ptr = OWNER_ICU;
`endif

  biu_arb_pri u_pri (
    .icu_req (icu_biu_req),
    .dcu_req (dcu_biu_req),
    .ptr     (ptr),
    .grant   (grant)
  );

  assign in_req     = (state == ST_REQ);
  assign in_data    = (state == ST_DATA);
  assign burst_done = in_data && axi_arb_data_valid && axi_arb_data_last;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner and its address when leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner        <= OWNER_ICU;
      arb_axi_addr <= '0;
    end else if ((state == ST_IDLE) && (grant != 2'b00)) begin
      owner        <= grant[1] ? OWNER_DCU : OWNER_ICU;
      arb_axi_addr <= grant[1] ? dcu_biu_addr : icu_biu_addr;
    end
  end

  // Next-state logic; a finished burst always returns through IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant != 2'b00) state_nxt = ST_REQ;
      ST_REQ:  if (axi_arb_ack)    state_nxt = ST_DATA;
      ST_DATA: if (burst_done)     state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output routing: only the owner ever sees ack/beats, and only in the
  // state where they are meaningful; stray response strobes are dropped.
  always_comb begin
    biu_icu_ack        = 1'b0;
    biu_dcu_ack        = 1'b0;
    biu_icu_data_valid = 1'b0;
    biu_dcu_data_valid = 1'b0;
    biu_icu_data_last  = 1'b0;
    biu_dcu_data_last  = 1'b0;
    biu_icu_data       = '0;
    biu_dcu_data       = '0;
    if (in_req && axi_arb_ack) begin
      if (owner == OWNER_DCU) biu_dcu_ack = 1'b1;
      else                    biu_icu_ack = 1'b1;
    end
    if (in_data) begin
      if (owner == OWNER_DCU) begin
        biu_dcu_data_valid = axi_arb_data_valid;
        biu_dcu_data_last  = axi_arb_data_last;
        biu_dcu_data       = axi_arb_data;
      end else begin
        biu_icu_data_valid = axi_arb_data_valid;
        biu_icu_data_last  = axi_arb_data_last;
        biu_icu_data       = axi_arb_data;
      end
    end
  end

  assign arb_axi_req = in_req;
  assign arb_busy    = (state != ST_IDLE);
  assign arb_owner   = arb_busy ? owner : OWNER_ICU;
  assign arb_state   = state;

endmodule

// File: tb/tb_biu_arb.sv
// Directed bench for biu_arb: single refill, tie-break, back-to-back
// arbitration, stray beats and mid-burst reset.
import biu_arb_pkg::*;

module tb_biu_arb;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam logic [AW-1:0] ICU_A = 32'h0001_0108;
  localparam logic [AW-1:0] DCU_A = 32'h0002_0200;

  // Clock / reset / DUT signals.
  logic          clk;
  logic          reset;
  logic          icu_biu_req, dcu_biu_req;
  logic [AW-1:0] icu_biu_addr, dcu_biu_addr;
  logic          biu_icu_ack, biu_dcu_ack;
  logic          biu_icu_data_valid, biu_dcu_data_valid;
  logic          biu_icu_data_last, biu_dcu_data_last;
  logic [DW-1:0] biu_icu_data, biu_dcu_data;
  logic          arb_axi_req;
  logic [AW-1:0] arb_axi_addr;
  logic          axi_arb_ack, axi_arb_data_valid, axi_arb_data_last;
  logic [DW-1:0] axi_arb_data;
  logic          arb_owner, arb_busy;
  state_e        arb_state;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] beat_pat [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  biu_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .icu_biu_req        (icu_biu_req),
    .icu_biu_addr       (icu_biu_addr),
    .dcu_biu_req        (dcu_biu_req),
    .dcu_biu_addr       (dcu_biu_addr),
    .biu_icu_ack        (biu_icu_ack),
    .biu_dcu_ack        (biu_dcu_ack),
    .biu_icu_data_valid (biu_icu_data_valid),
    .biu_dcu_data_valid (biu_dcu_data_valid),
    .biu_icu_data_last  (biu_icu_data_last),
    .biu_dcu_data_last  (biu_dcu_data_last),
    .biu_icu_data       (biu_icu_data),
    .biu_dcu_data       (biu_dcu_data),
    .arb_axi_req        (arb_axi_req),
    .arb_axi_addr       (arb_axi_addr),
    .axi_arb_ack        (axi_arb_ack),
    .axi_arb_data_valid (axi_arb_data_valid),
    .axi_arb_data_last  (axi_arb_data_last),
    .axi_arb_data       (axi_arb_data),
    .arb_owner          (arb_owner),
    .arb_busy           (arb_busy),
    .arb_state          (arb_state)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Neither requester sees any response strobe or payload.
  task automatic chk_quiet(input string tag);
    chk({tag, "_icu_ack"},   biu_icu_ack, 0);
    chk({tag, "_dcu_ack"},   biu_dcu_ack, 0);
    chk({tag, "_icu_valid"}, biu_icu_data_valid, 0);
    chk({tag, "_dcu_valid"}, biu_dcu_data_valid, 0);
    chk({tag, "_icu_last"},  biu_icu_data_last, 0);
    chk({tag, "_dcu_last"},  biu_dcu_data_last, 0);
    chk({tag, "_icu_data"},  biu_icu_data, 0);
    chk({tag, "_dcu_data"},  biu_dcu_data, 0);
  endtask

  // Wait (bounded) for a downstream request, check owner/addr, ack it,
  // optionally drop the owner's request, then deliver nbeats beats.
  task automatic run_burst(input string tag, input logic exp_owner,
                           input logic [AW-1:0] exp_addr, input int nbeats,
                           input bit drop_req);
    for (int w = 0; w < 10 && !arb_axi_req; w++) tick();
    chk({tag, "_axi_req"}, arb_axi_req, 1);
    chk({tag, "_owner"},   arb_owner, exp_owner);
    chk({tag, "_addr"},    arb_axi_addr, exp_addr);
    chk({tag, "_busy"},    arb_busy, 1);
    axi_arb_ack = 1'b1;
    #1;
    chk({tag, "_icu_ack"}, biu_icu_ack, exp_owner == OWNER_ICU);
    chk({tag, "_dcu_ack"}, biu_dcu_ack, exp_owner == OWNER_DCU);
    tick();
    axi_arb_ack = 1'b0;
    if (drop_req) begin
      if (exp_owner == OWNER_ICU) icu_biu_req = 1'b0;
      else                        dcu_biu_req = 1'b0;
    end
    chk({tag, "_axi_req_drop"}, arb_axi_req, 0);
    for (int b = 0; b < nbeats; b++) begin
      axi_arb_data_valid = 1'b1;
      axi_arb_data_last  = (b == nbeats - 1);
      axi_arb_data       = beat_pat[b];
      #1;
      if (exp_owner == OWNER_ICU) begin
        chk({tag, "_icu_valid"}, biu_icu_data_valid, 1);
        chk({tag, "_icu_last"},  biu_icu_data_last, b == nbeats - 1);
        chk({tag, "_icu_data"},  biu_icu_data, beat_pat[b]);
        chk({tag, "_dcu_valid"}, biu_dcu_data_valid, 0);
        chk({tag, "_dcu_data"},  biu_dcu_data, 0);
      end else begin
        chk({tag, "_dcu_valid"}, biu_dcu_data_valid, 1);
        chk({tag, "_dcu_last"},  biu_dcu_data_last, b == nbeats - 1);
        chk({tag, "_dcu_data"},  biu_dcu_data, beat_pat[b]);
        chk({tag, "_icu_valid"}, biu_icu_data_valid, 0);
        chk({tag, "_icu_data"},  biu_icu_data, 0);
      end
      tick();
    end
    axi_arb_data_valid = 1'b0;
    axi_arb_data_last  = 1'b0;
    axi_arb_data       = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] exp_seq;
    beat_pat[0] = 64'hbbbb_bbbb_bbbb_bbbb;
    beat_pat[1] = 64'hcccc_cccc_cccc_cccc;
    beat_pat[2] = 64'hdddd_dddd_dddd_dddd;
    beat_pat[3] = 64'heeee_eeee_eeee_eeee;

    reset = 1'b1;
    icu_biu_req = 1'b0; icu_biu_addr = ICU_A;
    dcu_biu_req = 1'b0; dcu_biu_addr = DCU_A;
    axi_arb_ack = 1'b0; axi_arb_data_valid = 1'b0;
    axi_arb_data_last = 1'b0; axi_arb_data = '0;
    tick(); tick();

    // Reset state.
    chk("rst_state", arb_state, ST_IDLE);
    chk("rst_axi_req", arb_axi_req, 0);
    chk("rst_axi_addr", arb_axi_addr, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_owner", arb_owner, 0);
    chk_quiet("rst");
    reset = 1'b0;
    tick();

    // Single icu refill: request sampled at next edge, arb_axi_req after it.
    icu_biu_req = 1'b1;
    #1;
    chk("s1_req_same_cycle", arb_axi_req, 0);
    tick();
    chk("s1_req_next_cycle", arb_axi_req, 1);
    run_burst("s1", OWNER_ICU, ICU_A, 4, 1'b1);
    chk("s1_end_busy", arb_busy, 0);
    chk_quiet("s1_end");

    // Stray beats in IDLE and in REQ are not forwarded.
    axi_arb_data_valid = 1'b1; axi_arb_data_last = 1'b1;
    axi_arb_data = 64'h1234_5678_9abc_def0;
    #1;
    chk_quiet("stray_idle");
    dcu_biu_req = 1'b1;
    tick();
    chk("stray_state_req", arb_state, ST_REQ);
    chk_quiet("stray_req");
    tick();
    chk("stray_still_req", arb_state, ST_REQ);
    axi_arb_data_valid = 1'b0; axi_arb_data_last = 1'b0; axi_arb_data = '0;
    run_burst("s2", OWNER_DCU, DCU_A, 1, 1'b1);

    // Simultaneous requests: icu first, dcu one bubble after icu's last beat.
    icu_biu_req = 1'b1; dcu_biu_req = 1'b1;
    tick();
    run_burst("s3_icu", OWNER_ICU, ICU_A, 2, 1'b1);
    chk("s3_bubble_busy", arb_busy, 0);
    chk("s3_bubble_req", arb_axi_req, 0);
    tick();
    chk("s3_regrant_req", arb_axi_req, 1);
    run_burst("s3_dcu", OWNER_DCU, DCU_A, 2, 1'b1);

    // Both held continuously for three grants.
`ifdef BIU_ARB_RR_EN
    exp_seq = 3'b010;
`else
    exp_seq = 3'b000;
`endif
    icu_biu_req = 1'b1; dcu_biu_req = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      run_burst("s4", exp_seq[g], exp_seq[g] ? DCU_A : ICU_A, 2, 1'b0);
      chk("s4_bubble_busy", arb_busy, 0);
      if (g == 2) begin
        icu_biu_req = 1'b0; dcu_biu_req = 1'b0;
      end
      tick();
    end
    chk("s4_idle_after", arb_busy, 0);

    // Reset pulsed after the second beat abandons the burst.
    icu_biu_req = 1'b1;
    tick();
    chk("s5_req", arb_axi_req, 1);
    axi_arb_ack = 1'b1;
    tick();
    axi_arb_ack = 1'b0; icu_biu_req = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axi_arb_data_valid = 1'b1; axi_arb_data = beat_pat[b];
      #1;
      chk("s5_pre_valid", biu_icu_data_valid, 1);
      chk("s5_pre_data", biu_icu_data, beat_pat[b]);
      tick();
    end
    axi_arb_data = beat_pat[2];
    reset = 1'b1;
    #1;
    chk("s5_rst_state", arb_state, ST_IDLE);
    chk("s5_rst_axi_req", arb_axi_req, 0);
    chk("s5_rst_addr", arb_axi_addr, 0);
    chk("s5_rst_busy", arb_busy, 0);
    chk_quiet("s5_rst");
    tick();
    reset = 1'b0;
    axi_arb_data = beat_pat[3]; axi_arb_data_last = 1'b1;
    #1;
    chk_quiet("s5_drop");
    chk("s5_drop_busy", arb_busy, 0);
    tick();
    axi_arb_data_valid = 1'b0; axi_arb_data_last = 1'b0; axi_arb_data = '0;
    icu_biu_req = 1'b1;
    tick();
    run_burst("s5_new", OWNER_ICU, ICU_A, 4, 1'b1);
    chk("s5_new_end", arb_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/biu_arb.md
BIU_ARB -- requirements
Module: biu_arb

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the refill beat width.
REQ-002 Parameter ADDR_W, default 32, SHALL set the request address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be asynchronous, active-high.
REQ-005 icu_biu_req  input  1  SHALL be the icache refill request, level, held until biu_icu_ack.
REQ-006 icu_biu_addr  input  ADDR_W  SHALL be the icache line address, valid with icu_biu_req.
REQ-007 dcu_biu_req  input  1  SHALL be the dcache refill request, same rules as icu_biu_req.
REQ-008 dcu_biu_addr  input  ADDR_W  SHALL be the dcache line address.
REQ-009 biu_icu_ack, biu_dcu_ack  output  1 each  SHALL each be the one-cycle request accept to the owner.
REQ-010 biu_icu_data_valid, biu_dcu_data_valid  output  1 each  SHALL each be the beat valid to the owner.
REQ-011 biu_icu_data_last, biu_dcu_data_last  output  1 each  SHALL each mark the owner's final beat.
REQ-012 biu_icu_data, biu_dcu_data  output  DATA_W each  SHALL each be the beat payload.
REQ-013 arb_axi_req  output  1, arb_axi_addr  output  ADDR_W  SHALL be the downstream bus request/address.
REQ-014 axi_arb_ack, axi_arb_data_valid, axi_arb_data_last  input  1 each; axi_arb_data  input  DATA_W  SHALL be the downstream response.
REQ-015 arb_owner  output  1  SHALL indicate the current grant (0 = icu, 1 = dcu), valid when arb_busy=1; arb_busy  output  1.

Function
REQ-016 FSM states SHALL be IDLE, REQ, DATA.
REQ-017 IDLE: with any request, winner SHALL be latched into owner, its address into arb_axi_addr, next state REQ; else stay IDLE.
REQ-018 Latency: request sampled at edge N SHALL give arb_axi_req=1 from cycle N+1.
REQ-019 REQ: arb_axi_req=1; on axi_arb_ack, the owner's ack SHALL be driven combinationally in the same cycle, arb_axi_req SHALL drop next cycle, next state DATA.
REQ-020 Non-owner ack, data_valid, data_last and data SHALL be 0 at all times.
REQ-021 DATA: axi_arb_data_valid/data_last/data SHALL be routed combinationally to the owner; on data_valid&&data_last, next state IDLE.
REQ-022 data_valid or data_last arriving in IDLE or REQ SHALL be ignored (not forwarded).
REQ-023 Request drop after grant SHALL be ignored; burst completes to the latched owner.
REQ-024 Last beat with a pending request SHALL pass through IDLE for one bubble cycle before re-grant.
REQ-025 Fixed priority (macro absent): icu SHALL win simultaneous requests.
REQ-026 arb_busy SHALL be 1 in REQ and DATA, 0 in IDLE.

Reset
REQ-027 On reset: state IDLE, all outputs 0, arb_axi_addr 0, owner 0, priority pointer to icu.
REQ-028 Reset mid-burst SHALL abandon the burst; beats after release are dropped per REQ-022.

Configuration
REQ-029 With BIU_ARB_RR_EN defined, a priority pointer SHALL favour the requester not served last, toggling on every completed last beat.
REQ-030 Without BIU_ARB_RR_EN, fixed icu priority SHALL apply and no pointer flop SHALL exist.

Structure
REQ-031 Package biu_arb_pkg SHALL hold the FSM state enum, the owner encoding constants (OWNER_ICU=0, OWNER_DCU=1) and default widths.
REQ-032 Winner selection SHALL be a sub-module biu_arb_pri (two requests plus pointer in, one-hot grant out).

Verification
REQ-033 icu_biu_req, addr 0x00010108 alone -> arb_axi_req at next cycle with addr 0x00010108; ack -> biu_icu_ack same cycle; 4 beats 0xbbbb..., 0xcccc..., 0xdddd..., 0xeeee... with last on the 4th -> biu_icu_data matches, dcu outputs 0.
REQ-034 icu and dcu requests in same cycle -> icu served first, dcu granted one cycle after icu's last beat.
REQ-035 With BIU_ARB_RR_EN: icu and dcu held continuously -> grants alternate icu, dcu, icu; without the macro -> icu, icu, icu.
REQ-036 Stray axi_arb_data_valid=1 in IDLE and in REQ -> no data_valid on either requester.
REQ-037 reset pulsed after 2nd beat -> all outputs 0 next cycle, remaining beats dropped, new icu request served normally.
